// File: rtl/ans_pkg.sv
// Shared rANS encoder constants and types.
package ans_pkg;

    localparam int unsigned ANS_STATE_W = 32;
    localparam int unsigned ANS_L_BITS  = 23;
    localparam logic [ANS_STATE_W-1:0] ANS_L_INIT = ANS_STATE_W'(1) << ANS_L_BITS;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RENORM = 3'd1,
        DIV    = 3'd2,
        UPDATE = 3'd3,
        FLUSH  = 3'd4
    } ans_state_e;

    typedef logic [1:0] flush_idx_t;

endpackage

// File: rtl/ans_seq_divider.sv
// Restoring 32-bit by DIV_W-bit divider, one quotient bit per cycle.
// The start cycle already resolves the first bit, so done follows 32 cycles after start.
module ans_seq_divider #(
    parameter int unsigned DIV_W = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [31:0]      i_dividend,
    input  logic [DIV_W-1:0] i_divisor,
    output logic             o_done,
    output logic [31:0]      o_quotient,
    output logic [DIV_W-1:0] o_remainder
);

    logic [31:0]      r_quot;
    logic [DIV_W-1:0] r_rem;
    logic [DIV_W-1:0] r_div;
    logic [4:0]       r_cnt;
    logic             r_active;
    logic             r_done;

    logic [31:0]      w_q_in;
    logic [DIV_W-1:0] w_rem_in;
    logic [DIV_W-1:0] w_div;
    logic [DIV_W:0]   w_trial;
    logic [DIV_W:0]   w_diff;
    logic             w_ge;
    logic [DIV_W-1:0] w_rem_next;

    assign w_q_in     = i_start ? i_dividend : r_quot;
    assign w_rem_in   = i_start ? '0 : r_rem;
    assign w_div      = i_start ? i_divisor : r_div;
    assign w_trial    = {w_rem_in, w_q_in[31]};
    assign w_ge       = w_trial >= {1'b0, w_div};
    assign w_diff     = w_trial - {1'b0, w_div};
    assign w_rem_next = w_ge ? w_diff[DIV_W-1:0] : w_trial[DIV_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_quot   <= '0;
            r_rem    <= '0;
            r_div    <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_quot   <= {w_q_in[30:0], w_ge};
                r_rem    <= w_rem_next;
                r_div    <= i_divisor;
                r_cnt    <= 5'd1;
                r_active <= 1'b1;
            end else if (r_active) begin
                r_quot <= {w_q_in[30:0], w_ge};
                r_rem  <= w_rem_next;
                r_cnt  <= r_cnt + 5'd1;
                if (r_cnt == 5'd31) begin
                    r_active <= 1'b0;
                    r_done   <= 1'b1;
                end
            end
        end
    end

    assign o_done      = r_done;
    assign o_quotient  = r_quot;
    assign o_remainder = r_rem;

endmodule

// File: rtl/rans_encoder_core.sv
// rANS byte encoder core: renormalise, divide, update state, flush final state.
// Build option RANS_BYTE_COUNT_EN enables the byte_count counter (tied to zero otherwise).
module rans_encoder_core
    import ans_pkg::*;
#(
    parameter int unsigned PROB_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sym_valid,
    output logic                 sym_ready,
    input  logic [PROB_BITS:0]   sym_freq,
    input  logic [PROB_BITS-1:0] sym_start,
    input  logic                 flush_valid,
    output logic                 flush_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_byte,
    output logic                 busy,
    output logic                 err,
    output logic [31:0]          state_out,
    output logic [15:0]          byte_count
);

    localparam logic [PROB_BITS+1:0] TOTAL = (PROB_BITS+2)'(1) << PROB_BITS;

    ans_state_e              r_state;
    logic [ANS_STATE_W-1:0]  r_x;
    logic [PROB_BITS:0]      r_freq;
    logic [PROB_BITS-1:0]    r_start;
    logic                    r_err;
    logic                    r_out_valid;
    logic [7:0]              r_out_byte;
    flush_idx_t              r_fidx;

    logic [PROB_BITS+1:0]    w_sum;
    logic                    w_illegal;
    logic                    w_take;
    logic [ANS_STATE_W-1:0]  w_x_max;
    logic [ANS_STATE_W-1:0]  w_cand;
    logic                    w_renorm;
    logic                    w_div_start;
    logic                    w_div_done;
    logic [31:0]             w_quot;
    logic [PROB_BITS:0]      w_rem;
    flush_idx_t              w_fidx_next;
    logic [7:0]              w_flush_byte;

    assign w_sum        = {2'b00, sym_start} + {1'b0, sym_freq};
    assign w_illegal    = (sym_freq == '0) || ({1'b0, sym_freq} > TOTAL) || (w_sum > TOTAL);
    assign w_take       = r_out_valid & out_ready;
    assign w_x_max      = ANS_STATE_W'(r_freq) << (31 - PROB_BITS);
    // A byte taken this cycle is already shifted out before the next renorm decision.
    assign w_cand       = w_take ? (r_x >> 8) : r_x;
    assign w_renorm     = w_cand >= w_x_max;
    assign w_div_start  = (r_state == RENORM) && (!r_out_valid || out_ready) && !w_renorm;
    assign w_fidx_next  = r_fidx + 2'd1;
    assign w_flush_byte = r_x[{w_fidx_next, 3'b000} +: 8];

    ans_seq_divider #(.DIV_W(PROB_BITS + 1)) u_div (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (w_div_start),
        .i_dividend  (w_cand),
        .i_divisor   (r_freq),
        .o_done      (w_div_done),
        .o_quotient  (w_quot),
        .o_remainder (w_rem)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_x         <= ANS_L_INIT;
            r_freq      <= '0;
            r_start     <= '0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_byte  <= '0;
            r_fidx      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (flush_valid) begin
                        r_state     <= FLUSH;
                        r_fidx      <= '0;
                        r_out_valid <= 1'b1;
                        r_out_byte  <= r_x[7:0];
                    end else if (sym_valid) begin
                        if (w_illegal) begin
                            r_err <= 1'b1;
                        end else begin
                            r_freq  <= sym_freq;
                            r_start <= sym_start;
                            r_state <= RENORM;
                        end
                    end
                end
                RENORM: begin
                    if (!r_out_valid || out_ready) begin
                        r_x <= w_cand;
                        if (w_renorm) begin
                            r_out_valid <= 1'b1;
                            r_out_byte  <= w_cand[7:0];
                        end else begin
                            r_out_valid <= 1'b0;
                            r_state     <= DIV;
                        end
                    end
                end
                DIV: begin
                    if (w_div_done) begin
                        r_state <= UPDATE;
                    end
                end
                UPDATE: begin
                    r_x     <= (w_quot << PROB_BITS) + ANS_STATE_W'(w_rem) + ANS_STATE_W'(r_start);
                    r_state <= IDLE;
                end
                FLUSH: begin
                    if (out_ready) begin
                        if (r_fidx == 2'd3) begin
                            r_out_valid <= 1'b0;
                            r_x         <= ANS_L_INIT;
                            r_state     <= IDLE;
                        end else begin
                            r_fidx     <= w_fidx_next;
                            r_out_byte <= w_flush_byte;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef RANS_BYTE_COUNT_EN
    logic [15:0] r_byte_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_count <= '0;
        end else if (w_take) begin
            r_byte_count <= r_byte_count + 16'd1;
        end
    end

    assign byte_count = r_byte_count;
`else
    assign byte_count = '0;
`endif

    assign sym_ready   = (r_state == IDLE) && !flush_valid;
    assign flush_ready = (r_state == IDLE);
    assign busy        = (r_state != IDLE);
    assign out_valid   = r_out_valid;
    assign out_byte    = r_out_byte;
    assign err         = r_err;
    assign state_out   = r_x;

endmodule
